// File: rtl/q_inspect.sv
// -----------------------------------------------------------------------------
// q_inspect -- piece inspection stage feeding the station's flow-control FSM.
//
// On a rising DCE (piece arrives) a burst of 2**NSAMP_LOG2 sensor samples is
// accumulated and averaged. The average is checked against the inclusive window
// [LIM_LO, LIM_HI] and a POK / PNOK verdict level is held while the piece stays
// at the inspection point. Too few samples within TIMEOUT acquisition cycles
// forces a reject. Losing DCE before the verdict aborts silently.
//
// Ports:
//   CLK      in   1   system clock, rising edge
//   RST      in   1   synchronous active-high reset
//   DCE      in   1   entry sensor, piece present
//   SVALID   in   1   SDATA carries a valid sample this cycle
//   SDATA    in   W   unsigned sensor sample
//   POK      out  1   verdict level: piece within tolerance
//   PNOK     out  1   verdict level: piece rejected
//   BUSY     out  1   acquisition / decision in progress
//   AVG      out  W   last computed average
//   REJ_CNT  out  8   saturating reject counter (only with QINSP_REJCNT_EN)
//
// Build option:
//   QINSP_REJCNT_EN  -- adds the REJ_CNT port and its counter.
// -----------------------------------------------------------------------------
module q_inspect #(
    parameter int unsigned W          = 8,
    parameter int unsigned NSAMP_LOG2 = 2,
    parameter int unsigned LIM_LO     = 100,
    parameter int unsigned LIM_HI     = 150,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         DCE,
    input  logic         SVALID,
    input  logic [W-1:0] SDATA,
    output logic         POK,
    output logic         PNOK,
    output logic         BUSY,
    output logic [W-1:0] AVG
`ifdef QINSP_REJCNT_EN
    ,
    output logic [7:0]   REJ_CNT
`endif
);

    localparam int unsigned ACC_W = W + NSAMP_LOG2;
    localparam int unsigned CNT_W = NSAMP_LOG2 + 1;
    localparam int unsigned NSAMP = 1 << NSAMP_LOG2;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        DECIDE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state_q;
    logic               dce_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TMR_W-1:0]   tmr_q;
    logic               forced_q;
    logic               pok_q;
    logic               pnok_q;
    logic               busy_q;
    logic [W-1:0]       avg_q;
`ifdef QINSP_REJCNT_EN
    logic [7:0]         rej_q;
`endif

    // Combinational helpers for the state register below
    logic               dce_rise;
    logic               take_last;
    logic               timer_exp;
    logic [ACC_W-1:0]   acc_d;
    logic [W-1:0]       avg_d;
    logic               in_win;

    always_comb begin
        dce_rise  = DCE & ~dce_q;
        // This edge accepts the final sample of the burst
        take_last = SVALID && (cnt_q == CNT_W'(NSAMP - 1));
        timer_exp = (tmr_q == TMR_W'(TIMEOUT - 1));
        acc_d     = acc_q + ACC_W'(SDATA);
        // Truncating average; the accumulator is wide enough for N full-scale samples
        avg_d     = W'(acc_q >> NSAMP_LOG2);
        in_win    = (avg_d >= W'(LIM_LO)) && (avg_d <= W'(LIM_HI));
    end

    // Inspection FSM with registered verdict, busy and average outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            // Edge detector starts high so a piece already present is not inspected
            dce_q    <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            forced_q <= 1'b0;
            pok_q    <= 1'b0;
            pnok_q   <= 1'b0;
            busy_q   <= 1'b0;
            avg_q    <= '0;
`ifdef QINSP_REJCNT_EN
            rej_q    <= '0;
`endif
        end else begin
            dce_q <= DCE;
            case (state_q)
                IDLE: begin
                    if (dce_rise) begin
                        state_q  <= ACQ;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        tmr_q    <= '0;
                        forced_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                ACQ: begin
                    if (!DCE) begin
                        // Piece left before a verdict: drop the acquisition
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                        if (SVALID) begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        // Final sample wins over a coincident timeout
                        if (take_last) begin
                            state_q  <= DECIDE;
                            forced_q <= 1'b0;
                        end else if (timer_exp) begin
                            state_q  <= DECIDE;
                            forced_q <= 1'b1;
                        end
                    end
                end
                DECIDE: begin
                    if (!DCE) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        avg_q   <= avg_d;
                        state_q <= HOLD;
                        busy_q  <= 1'b0;
                        if (!forced_q && in_win) begin
                            pok_q <= 1'b1;
                        end else begin
                            pnok_q <= 1'b1;
`ifdef QINSP_REJCNT_EN
                            if (rej_q != 8'hFF) begin
                                rej_q <= rej_q + 8'd1;
                            end
`endif
                        end
                    end
                end
                HOLD: begin
                    // Verdict level lasts exactly as long as the piece is present
                    if (!DCE) begin
                        pok_q   <= 1'b0;
                        pnok_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign POK  = pok_q;
    assign PNOK = pnok_q;
    assign BUSY = busy_q;
    assign AVG  = avg_q;
`ifdef QINSP_REJCNT_EN
    assign REJ_CNT = rej_q;
`endif

endmodule

// File: tb/tb_q_inspect.sv
// -----------------------------------------------------------------------------
// tb_q_inspect -- self-checking bench for q_inspect.
// Directed scenarios plus randomized pieces checked against a transaction-level
// model (sample count, sum, window test). Honours QINSP_REJCNT_EN.
// -----------------------------------------------------------------------------
module tb_q_inspect;

    localparam int N   = 4;
    localparam int LO  = 100;
    localparam int HI  = 150;
    localparam int TMO = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic       DCE;
    logic       SVALID;
    logic [7:0] SDATA;
    logic       POK;
    logic       PNOK;
    logic       BUSY;
    logic [7:0] AVG;
`ifdef QINSP_REJCNT_EN
    logic [7:0] REJ_CNT;
`endif

    int checks = 0;
    int errors = 0;

    // Model state
    int exp_avg  = 0;
    bit exp_pok  = 1'b0;
    bit exp_pnok = 1'b0;
    int exp_rej  = 0;

    // Per-ACQ-cycle stimulus for one piece
    bit         sv_v[TMO];
    logic [7:0] sv_d[TMO];

    always #5 CLK = ~CLK;

    q_inspect #(
        .W(8), .NSAMP_LOG2(2), .LIM_LO(100), .LIM_HI(150), .TIMEOUT(16)
    ) dut (
        .CLK(CLK), .RST(RST), .DCE(DCE), .SVALID(SVALID), .SDATA(SDATA),
        .POK(POK), .PNOK(PNOK), .BUSY(BUSY), .AVG(AVG)
`ifdef QINSP_REJCNT_EN
        , .REJ_CNT(REJ_CNT)
`endif
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: walk the acquisition cycles, stop at N samples or at the timeout
    function automatic void ref_piece(output int ncyc, output int sum, output bit forced);
        int got;
        got = 0; sum = 0; forced = 1'b0; ncyc = TMO;
        for (int i = 0; i < TMO; i++) begin
            if (sv_v[i]) begin
                got++;
                sum += int'(sv_d[i]);
            end
            if (got == N) begin
                ncyc = i + 1;
                return;
            end
        end
        forced = 1'b1;
    endfunction

    task automatic set_samples(input int n, input int d0, input int d1, input int d2, input int d3);
        int d[4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < TMO; i++) begin
            sv_v[i] = (i < n);
            sv_d[i] = (i < n) ? 8'(d[i]) : 8'($urandom);
        end
    endtask

    function automatic void model_verdict(input int sum, input bit forced);
        exp_avg  = sum / N;
        exp_pok  = !forced && (exp_avg >= LO) && (exp_avg <= HI);
        exp_pnok = !exp_pok;
        if (exp_pnok && exp_rej < 255) exp_rej++;
    endfunction

    // Drives one complete piece up to the verdict edge; DCE stays high afterwards
    task automatic run_piece();
        int ncyc, sum;
        bit forced;
        ref_piece(ncyc, sum, forced);
        DCE = 1'b0; SVALID = 1'b0; step();
        DCE = 1'b1; SVALID = 1'b1; SDATA = 8'($urandom); step();
        for (int i = 0; i < ncyc; i++) begin
            SVALID = sv_v[i]; SDATA = sv_d[i]; step();
        end
        SVALID = 1'b1; SDATA = 8'($urandom); step();
        SVALID = 1'b0;
        model_verdict(sum, forced);
    endtask

    task automatic test_reset();
        RST = 1'b1; DCE = 1'b0; SVALID = 1'b0; SDATA = '0;
        step(); step();
        checks++; if (POK !== 1'b0)  begin errors++; $display("FAIL reset_pok got %0b exp 0", POK); end
        checks++; if (PNOK !== 1'b0) begin errors++; $display("FAIL reset_pnok got %0b exp 0", PNOK); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", BUSY); end
        checks++; if (AVG !== 8'd0)  begin errors++; $display("FAIL reset_avg got %0d exp 0", AVG); end
`ifdef QINSP_REJCNT_EN
        checks++; if (REJ_CNT !== 8'd0) begin errors++; $display("FAIL reset_rej got %0d exp 0", REJ_CNT); end
`endif
        RST = 1'b0;
        exp_avg = 0; exp_rej = 0;
    endtask

    task automatic test_pass();
        int smp[4];
        smp = '{120, 130, 110, 140};
        DCE = 1'b0; SVALID = 1'b0; step();
        DCE = 1'b1; step();
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL pass_busy_acq got %0b exp 1", BUSY); end
        for (int i = 0; i < 4; i++) begin
            SVALID = 1'b1; SDATA = 8'(smp[i]); step();
        end
        checks++; if (POK !== 1'b0 || BUSY !== 1'b1) begin
            errors++; $display("FAIL pass_decide_early pok=%0b busy=%0b exp pok=0 busy=1", POK, BUSY); end
        SVALID = 1'b0; step();
        checks++; if (AVG !== 8'd125) begin errors++; $display("FAIL pass_avg got %0d exp 125", AVG); end
        checks++; if (POK !== 1'b1 || PNOK !== 1'b0) begin
            errors++; $display("FAIL pass_verdict pok=%0b pnok=%0b exp pok=1 pnok=0", POK, PNOK); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL pass_busy_done got %0b exp 0", BUSY); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (POK !== 1'b1) begin errors++; $display("FAIL pass_hold got %0b exp 1", POK); end
        end
        DCE = 1'b0; step();
        checks++; if (POK !== 1'b0 || PNOK !== 1'b0) begin
            errors++; $display("FAIL pass_release pok=%0b pnok=%0b exp 0 0", POK, PNOK); end
        exp_avg = 125;
    endtask

    task automatic test_reject_high();
        set_samples(4, 200, 200, 200, 200);
        run_piece();
        checks++; if (AVG !== 8'd200) begin errors++; $display("FAIL rejhi_avg got %0d exp 200", AVG); end
        checks++; if (PNOK !== 1'b1 || POK !== 1'b0) begin
            errors++; $display("FAIL rejhi_verdict pok=%0b pnok=%0b exp pok=0 pnok=1", POK, PNOK); end
`ifdef QINSP_REJCNT_EN
        checks++; if (REJ_CNT !== 8'd1) begin errors++; $display("FAIL rejhi_cnt got %0d exp 1", REJ_CNT); end
`endif
    endtask

    task automatic test_boundaries();
        int bd[4][4];
        int bavg[4];
        bit bok[4];
        bd   = '{'{100, 100, 100, 103}, '{150, 150, 150, 153}, '{151, 151, 151, 151}, '{99, 99, 99, 99}};
        bavg = '{100, 150, 151, 99};
        bok  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            set_samples(4, bd[c][0], bd[c][1], bd[c][2], bd[c][3]);
            run_piece();
            checks++; if (AVG !== 8'(bavg[c])) begin
                errors++; $display("FAIL bound%0d_avg got %0d exp %0d", c, AVG, bavg[c]); end
            checks++; if (POK !== bok[c] || PNOK !== !bok[c]) begin
                errors++; $display("FAIL bound%0d_verdict pok=%0b pnok=%0b exp pok=%0b", c, POK, PNOK, bok[c]); end
        end
    endtask

    task automatic test_timeout();
        DCE = 1'b0; SVALID = 1'b0; step();
        DCE = 1'b1; step();
        for (int i = 0; i < TMO; i++) begin
            SVALID = (i < 2); SDATA = (i < 2) ? 8'd120 : 8'($urandom); step();
            checks++; if (PNOK !== 1'b0 || BUSY !== 1'b1) begin
                errors++; $display("FAIL tmo_early cyc%0d pnok=%0b busy=%0b exp pnok=0 busy=1", i, PNOK, BUSY); end
        end
        SVALID = 1'b0; step();
        checks++; if (PNOK !== 1'b1 || POK !== 1'b0) begin
            errors++; $display("FAIL tmo_verdict pok=%0b pnok=%0b exp pok=0 pnok=1", POK, PNOK); end
        checks++; if (AVG !== 8'd60) begin errors++; $display("FAIL tmo_avg got %0d exp 60", AVG); end
        exp_avg = 60;
        if (exp_rej < 255) exp_rej++;
`ifdef QINSP_REJCNT_EN
        checks++; if (REJ_CNT !== 8'(exp_rej)) begin
            errors++; $display("FAIL tmo_rej got %0d exp %0d", REJ_CNT, exp_rej); end
`endif
    endtask

    task automatic test_abort();
        // Abort during acquisition
        DCE = 1'b0; SVALID = 1'b0; step();
        DCE = 1'b1; step();
        SVALID = 1'b1; SDATA = 8'd10; step();
        SDATA = 8'd20; step();
        DCE = 1'b0; SVALID = 1'b0; step();
        checks++; if (BUSY !== 1'b0 || POK !== 1'b0 || PNOK !== 1'b0) begin
            errors++; $display("FAIL abort_acq busy=%0b pok=%0b pnok=%0b exp 0 0 0", BUSY, POK, PNOK); end
        checks++; if (AVG !== 8'(exp_avg)) begin
            errors++; $display("FAIL abort_acq_avg got %0d exp %0d", AVG, exp_avg); end
        // Abort on the decide edge
        DCE = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            SVALID = 1'b1; SDATA = 8'd30; step();
        end
        DCE = 1'b0; SVALID = 1'b0; step();
        checks++; if (BUSY !== 1'b0 || POK !== 1'b0 || PNOK !== 1'b0) begin
            errors++; $display("FAIL abort_dec busy=%0b pok=%0b pnok=%0b exp 0 0 0", BUSY, POK, PNOK); end
        checks++; if (AVG !== 8'(exp_avg)) begin
            errors++; $display("FAIL abort_dec_avg got %0d exp %0d", AVG, exp_avg); end
`ifdef QINSP_REJCNT_EN
        checks++; if (REJ_CNT !== 8'(exp_rej)) begin
            errors++; $display("FAIL abort_rej got %0d exp %0d", REJ_CNT, exp_rej); end
`endif
    endtask

    task automatic test_random();
        int thresh;
        int hold;
        for (int p = 0; p < 40; p++) begin
            thresh = $urandom_range(10, 100);
            for (int i = 0; i < TMO; i++) begin
                sv_v[i] = ($urandom_range(1, 100) <= thresh);
                sv_d[i] = 8'($urandom_range(80, 170));
            end
            run_piece();
            checks++; if (AVG !== 8'(exp_avg)) begin
                errors++; $display("FAIL rnd%0d_avg got %0d exp %0d", p, AVG, exp_avg); end
            checks++; if (POK !== exp_pok || PNOK !== exp_pnok || BUSY !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_verdict pok=%0b pnok=%0b busy=%0b exp pok=%0b pnok=%0b busy=0",
                                   p, POK, PNOK, BUSY, exp_pok, exp_pnok); end
`ifdef QINSP_REJCNT_EN
            checks++; if (REJ_CNT !== 8'(exp_rej)) begin
                errors++; $display("FAIL rnd%0d_rej got %0d exp %0d", p, REJ_CNT, exp_rej); end
`endif
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                SVALID = 1'($urandom); SDATA = 8'($urandom); step();
                checks++; if (POK !== exp_pok || PNOK !== exp_pnok) begin
                    errors++; $display("FAIL rnd%0d_hold pok=%0b pnok=%0b exp pok=%0b pnok=%0b",
                                       p, POK, PNOK, exp_pok, exp_pnok); end
            end
            SVALID = 1'b0;
        end
    endtask

    task automatic test_reset_hold();
        set_samples(4, 120, 120, 120, 120);
        run_piece();
        checks++; if (POK !== 1'b1) begin errors++; $display("FAIL rsthold_pre got %0b exp 1", POK); end
        RST = 1'b1; step();
        checks++; if (POK !== 1'b0 || PNOK !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL rsthold_flags pok=%0b pnok=%0b busy=%0b exp 0 0 0", POK, PNOK, BUSY); end
        checks++; if (AVG !== 8'd0) begin errors++; $display("FAIL rsthold_avg got %0d exp 0", AVG); end
        exp_avg = 0; exp_rej = 0;
    endtask

    task automatic test_reset_release();
        // DCE already high while RST is released: no acquisition
        RST = 1'b1; DCE = 1'b1; SVALID = 1'b0; step();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            SVALID = 1'b1; SDATA = 8'd125; step();
            checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rstrel_busy cyc%0d got %0b exp 0", i, BUSY); end
        end
        SVALID = 1'b0; step();
        checks++; if (POK !== 1'b0 || PNOK !== 1'b0 || AVG !== 8'd0) begin
            errors++; $display("FAIL rstrel_idle pok=%0b pnok=%0b avg=%0d exp 0 0 0", POK, PNOK, AVG); end
        // A genuine rise afterwards still starts an acquisition
        DCE = 1'b0; step();
        DCE = 1'b1; step();
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL rstrel_rise got %0b exp 1", BUSY); end
        DCE = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_pass();
        test_reject_high();
        test_boundaries();
        test_timeout();
        test_abort();
        test_random();
        test_reset_hold();
        test_reset_release();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
